// File: rtl/clf_pkg.sv
// Shared types and width helpers for the streaming classification head.
package clf_pkg;

   typedef enum logic [1:0] {StIdle, StAccum, StMac, StOut} clf_state_t;

   localparam int unsigned SatMaxW = 128;
   localparam logic signed [SatMaxW-1:0] SatOne = {{(SatMaxW-1){1'b0}}, 1'b1};

   function automatic int unsigned sum_w(input int unsigned dw, input int unsigned n);
      return dw + $clog2(n);
   endfunction

   function automatic int unsigned acc_w(input int unsigned dw, input int unsigned e);
      return 2 * dw + $clog2(e) + 2;
   endfunction

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Clamp a sign-extended value to the signed range of a dw-bit word.
   function automatic logic signed [SatMaxW-1:0] sat_q(input logic signed [SatMaxW-1:0] in,
                                                       input int unsigned dw);
      logic signed [SatMaxW-1:0] hi;
      logic signed [SatMaxW-1:0] lo;
      hi = (SatOne <<< (dw - 1)) - SatOne;
      lo = ~hi;
      if (in > hi) begin
         return hi;
      end else if (in < lo) begin
         return lo;
      end
      return in;
   endfunction

endpackage

// File: rtl/classification_head_stream_mac.sv
// Time-multiplexed MAC for one logit: accumulate, add bias on last, floor-shift and saturate.
module clf_mac_unit
   import clf_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned FRAC_BITS  = 15,
   parameter int unsigned E          = 64
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         clr,
   input  logic                         en,
   input  logic                         last,
   input  logic signed [DATA_WIDTH-1:0] a,
   input  logic signed [DATA_WIDTH-1:0] w,
   input  logic signed [DATA_WIDTH-1:0] b,
   output logic signed [DATA_WIDTH-1:0] logit,
   output logic                         sat
);

   localparam int unsigned AccW = acc_w(DATA_WIDTH, E);
   localparam int unsigned PW   = 2 * DATA_WIDTH;

   logic signed [PW-1:0]      prod;
   logic signed [AccW-1:0]    acc_q, acc_d, total, scaled;
   logic signed [SatMaxW-1:0] wide, narrowed;

   always_comb begin
      prod     = PW'(a) * PW'(w);
      total    = acc_q + AccW'(prod) + (AccW'(b) <<< FRAC_BITS);
      scaled   = total >>> FRAC_BITS;
      wide     = SatMaxW'(scaled);
      narrowed = sat_q(wide, DATA_WIDTH);
      logit    = DATA_WIDTH'(narrowed);
      sat      = (narrowed != wide);
      acc_d    = acc_q;
      if (clr) begin
         acc_d = '0;
      end else if (en) begin
         acc_d = last ? '0 : acc_q + AccW'(prod);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

endmodule

// File: rtl/classification_head_stream.sv
// Streaming classification head: pool N tokens, then NUM_CLASSES logits through one MAC.
// Optional argmax output is enabled by defining CLF_ARGMAX_EN.
module classification_head_stream
   import clf_pkg::*;
#(
   parameter int unsigned DATA_WIDTH  = 16,
   parameter int unsigned FRAC_BITS   = 15,
   parameter int unsigned E           = 64,
   parameter int unsigned N           = 16,
   parameter int unsigned NUM_CLASSES = 10
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         tok_valid,
   output logic                         tok_ready,
   input  logic signed [DATA_WIDTH-1:0] tok_data   [0:E-1],
   input  logic signed [DATA_WIDTH-1:0] W_clf_in   [0:E*NUM_CLASSES-1],
   input  logic signed [DATA_WIDTH-1:0] b_clf_in   [0:NUM_CLASSES-1],
   output logic signed [DATA_WIDTH-1:0] logits_out [0:NUM_CLASSES-1],
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         busy,
   output logic                         sat_flag
`ifdef CLF_ARGMAX_EN
   ,
   output logic [idx_w(NUM_CLASSES)-1:0] argmax_out
`endif
);

   localparam int unsigned SumW   = sum_w(DATA_WIDTH, N);
   localparam int unsigned LogN   = $clog2(N);
   localparam int unsigned CntW   = idx_w(N);
   localparam int unsigned IW     = idx_w(E);
   localparam int unsigned CW     = idx_w(NUM_CLASSES);
   localparam int unsigned WIdxW  = idx_w(E * NUM_CLASSES);

   clf_state_t                  state_q;
   logic signed [SumW-1:0]      sum_q [0:E-1];
   logic [CntW-1:0]             cnt_q;
   logic [IW-1:0]               i_q;
   logic [CW-1:0]               c_q;
   logic [WIdxW-1:0]            w_idx;
   logic signed [DATA_WIDTH-1:0] mean;
   logic signed [DATA_WIDTH-1:0] mac_logit;
   logic                         mac_sat;
   logic                         last;
`ifdef CLF_ARGMAX_EN
   logic signed [DATA_WIDTH-1:0] max_q;
`endif

   always_comb begin
      // Arithmetic shift of the pooled sum gives a floored mean.
      mean  = DATA_WIDTH'(sum_q[i_q] >>> LogN);
      w_idx = WIdxW'(c_q) * WIdxW'(E) + WIdxW'(i_q);
      last  = (i_q == IW'(E - 1));
   end

   clf_mac_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .FRAC_BITS  (FRAC_BITS),
      .E          (E)
   ) u_mac (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_q == StIdle),
      .en    (state_q == StMac),
      .last  (last),
      .a     (mean),
      .w     (W_clf_in[w_idx]),
      .b     (b_clf_in[c_q]),
      .logit (mac_logit),
      .sat   (mac_sat)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         i_q       <= '0;
         c_q       <= '0;
         tok_ready <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         sat_flag  <= 1'b0;
         for (int unsigned k = 0; k < E; k++) sum_q[k] <= '0;
         for (int unsigned k = 0; k < NUM_CLASSES; k++) logits_out[k] <= '0;
`ifdef CLF_ARGMAX_EN
         max_q      <= '0;
         argmax_out <= '0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (start) begin
                  for (int unsigned k = 0; k < E; k++) sum_q[k] <= '0;
                  cnt_q     <= '0;
                  sat_flag  <= 1'b0;
                  state_q   <= StAccum;
                  tok_ready <= 1'b1;
                  busy      <= 1'b1;
`ifdef CLF_ARGMAX_EN
                  max_q     <= '0;
`endif
               end
            end
            StAccum: begin
               if (tok_valid) begin
                  for (int unsigned k = 0; k < E; k++) begin
                     sum_q[k] <= sum_q[k] + SumW'(tok_data[k]);
                  end
                  cnt_q <= cnt_q + CntW'(1);
                  if (cnt_q == CntW'(N - 1)) begin
                     state_q   <= StMac;
                     tok_ready <= 1'b0;
                     i_q       <= '0;
                     c_q       <= '0;
                  end
               end
            end
            StMac: begin
               if (last) begin
                  logits_out[c_q] <= mac_logit;
                  if (mac_sat) sat_flag <= 1'b1;
`ifdef CLF_ARGMAX_EN
                  // Strict compare keeps the lowest index on ties.
                  if (c_q == '0 || mac_logit > max_q) begin
                     max_q      <= mac_logit;
                     argmax_out <= c_q;
                  end
`endif
                  i_q <= '0;
                  c_q <= c_q + CW'(1);
                  if (c_q == CW'(NUM_CLASSES - 1)) begin
                     state_q   <= StOut;
                     out_valid <= 1'b1;
                  end
               end else begin
                  i_q <= i_q + IW'(1);
               end
            end
            StOut: begin
               if (out_ready) begin
                  state_q   <= StIdle;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: doc/classification_head_stream.md
# classification_head_stream

Streaming, parametrised classification head for the transformer back-end. Accepts patch embeddings one token (E-vector) per valid/ready beat, global-average-pools them, then computes `NUM_CLASSES` logits with one time-multiplexed MAC in Qm.FRAC_BITS fixed point. It replaces the wide parallel pooling/dot-product head and presents results on a valid/ready output port. A compile-time option adds an argmax class index.

## Interface
- `DATA_WIDTH`, 16: signed width of tokens, weights, biases and logits.
- `FRAC_BITS`, 15: fractional bits of all fixed-point operands.
- `E`, 64: embedding length.
- `N`, 16: tokens per frame; must be a power of two, ≥2.
- `NUM_CLASSES`, 10: number of logits, ≥1.

- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: frame start pulse; honoured only in IDLE.
- `tok_valid` in 1: token beat valid.
- `tok_ready` out 1: token beat accepted when both high.
- `tok_data` in `DATA_WIDTH` × [0:E-1]: one token embedding.
- `W_clf_in` in `DATA_WIDTH` × [0:E*NUM_CLASSES-1]: weights, class-major (`c*E+i`); held stable from `start` to output handshake.
- `b_clf_in` in `DATA_WIDTH` × [0:NUM_CLASSES-1]: biases, same stability rule.
- `logits_out` out `DATA_WIDTH` × [0:NUM_CLASSES-1]: saturated logits.
- `out_valid` out 1: results valid. `out_ready` in 1: consumer accepts.
- `busy` out 1: high in any state but IDLE.
- `sat_flag` out 1: at least one logit of the current frame saturated.
- `argmax_out` out `$clog2(NUM_CLASSES)` (min 1): index of largest logit; present only with the macro.

## Operation
- States: IDLE → ACCUM → MAC → OUT → IDLE.
- IDLE: `tok_ready`=0. `start` clears all E sum registers, token counter, `sat_flag` and running max. Next state ACCUM.
- ACCUM: `tok_ready`=1. Each handshake adds `tok_data[i]` to `sum[i]` (width `DATA_WIDTH+$clog2(N)`, no overflow possible). Counter increments. On the N-th handshake go to MAC. Gaps in `tok_valid` stall without side effects.
- MAC: exactly `E*NUM_CLASSES` cycles. Indices (c,i) scan class-major.
  - `mean = sum[i] >>> $clog2(N)`: floor, fits `DATA_WIDTH`.
  - Product is signed `2*DATA_WIDTH`. Accumulator is `2*DATA_WIDTH+$clog2(E)+2` bits.
  - On i==E-1: total = acc + product + (sign-extended `b[c]` <<< FRAC_BITS). Then `logits_out[c]` = saturate(total >>> FRAC_BITS) to [-2^(DW-1), 2^(DW-1)-1]. Rounding is floor.
  - Saturation sets `sat_flag`. The accumulator clears.
- OUT: `out_valid`=1. `logits_out`, `sat_flag` and `argmax_out` stay stable until `out_valid && out_ready`, then go to IDLE.
- `start` outside IDLE is ignored. `start` with `tok_valid` in IDLE consumes no token.
- `logits_out` holds the last frame's values until overwritten during the next MAC.

## Timing
- Reset values: `tok_ready`=0, `out_valid`=0, `busy`=0, `sat_flag`=0, `logits_out`=0, `argmax_out`=0, state IDLE. Reset mid-frame aborts the frame immediately.
- `start` at cycle t → `tok_ready`=1 at t+1.
- Last token handshake at cycle t → MAC during t+1 … t+E·NUM_CLASSES → `out_valid`=1 at t+E·NUM_CLASSES+1.
- Minimum frame length is 1 + N + E·NUM_CLASSES + 1 cycles with `out_ready` tied high.
- Output handshake at cycle u → `busy`=0 at u+1. The earliest accepted `start` is at u+1.

## Configuration
- `CLF_ARGMAX_EN` defined:
  - Adds `argmax_out`.
  - During MAC each saturated logit is compared with the running max using strict greater-than, so ties resolve to the lowest index. Class 0 initialises the max.
  - Adds no latency.
- `CLF_ARGMAX_EN` undefined: the port and comparator logic are absent; all other behaviour is identical.

## Structure
- Package `clf_pkg` holds:
  - the state enum `clf_state_t`;
  - width functions for pooled sum and accumulator;
  - function `sat_q(in, DW)` for saturating narrowing.
- Sub-module `clf_mac_unit`: signed multiply, accumulate, bias add, shift and saturate, with a `last` strobe. It outputs the narrowed logit and a saturation bit.

## Test plan
Bench parameters: E=4, N=4, NUM_CLASSES=3; FRAC_BITS=15; all tokens 0x2000.
- Nominal: W0=all 0x2000, b0=0; W1=all 0x8000, b1=0; W2=all 0x7FFF, b2=0x7FFF → logits {0x2000, 0x8000, 0x7FFF}, `sat_flag`=1, `argmax_out`=2. `out_valid` is asserted 13 cycles after the 4th token handshake.
- Floor pooling: one token element0=0xFFFF, rest 0, W0[0]=0x7FFF, b=0 → logit0=0xFFFF, `sat_flag`=0.
- Token stalls: `tok_valid` toggles 1-0-0-1 → sums are unaffected, results match the nominal case, and `tok_ready` stays high in ACCUM.
- Backpressure: `out_ready` low for 5 cycles with `start` pulsed each cycle → outputs stable, `start` ignored, IDLE one cycle after `out_ready` rises.
- Tie/argmax: all weights and biases equal → `argmax_out`=0.
- Reset mid-MAC: `rst_n` low at MAC cycle 5 → all outputs at reset values. The next frame yields nominal results.
